// File: rtl/mem_port_arbiter4_pkg.sv
// Shared types for the four-way memory port arbiter: FSM states, requester
// count and the requester select type driven onto the parent's mux4.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam int NREQ = 4;

    typedef logic [1:0] req_sel_t;

    // One-hot strobe for the requester currently owning the port.
    function automatic logic [NREQ-1:0] sel_onehot(input req_sel_t s);
        return NREQ'(1) << s;
    endfunction

endpackage

// File: rtl/mem_port_arbiter4_rr_pick4.sv
// Round-robin pick: first asserted request scanning ptr, ptr+1, ptr+2, ptr+3
// (mod 4). Purely combinational.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [1:0] idx_o,
    output logic       any_o
);

    req_sel_t cand;

    // Scanning from the far end backwards lets the nearest hit overwrite.
    always_comb begin
        idx_o = ptr_i;
        cand  = ptr_i;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ptr_i + 2'(k);
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/mem_port_arbiter4.sv
// Round-robin arbiter sharing one memory port among four requesters, with
// request/accept/response sequencing and a stalled-memory timeout.
module mem_port_arbiter4
    import arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] req_valid_i,
    output logic [3:0] req_ready_o,
    output logic [3:0] rsp_valid_o,
    output logic       rsp_err_o,
    output logic [1:0] sel_o,
    output logic       mem_req_o,
    input  logic       mem_gnt_i,
    input  logic       mem_rvalid_i,
    output logic       busy_o,
    output logic       err_o,
    input  logic       err_clr_i
);

    localparam int TW = $clog2(TIMEOUT + 1);
    // The timer counts the current cycle too, so the limit is reached when
    // the registered count shows TIMEOUT-1.
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    arb_state_t    state_q, state_d;
    req_sel_t      sel_q, sel_d;
    req_sel_t      ptr_q, ptr_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;

    req_sel_t      pick_ptr;
    req_sel_t      pick_idx;
    logic          pick_any;
    req_sel_t      sel_next;
    logic [3:0]    sel_oh;
    logic          timeout_hit;

    assign sel_next    = sel_q + 2'd1;
    assign sel_oh      = sel_onehot(sel_q);
    assign timeout_hit = (timer_q == TLAST);

    // At a WAIT exit the pick must already see the pointer advanced past sel.
    assign pick_ptr = (state_q == WAIT) ? sel_next : ptr_q;

    rr_pick4 u_pick (
        .req_i (req_valid_i),
        .ptr_i (pick_ptr),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        timer_d     = timer_q;
        err_d       = err_q;
        req_ready_o = '0;
        rsp_valid_o = '0;
        rsp_err_o   = 1'b0;
        mem_req_o   = 1'b0;

        if (err_clr_i) begin
            err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (pick_any) begin
                    sel_d   = pick_idx;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    req_ready_o = sel_oh;
                    timer_d     = '0;
                    state_d     = WAIT;
                end else if (timeout_hit) begin
                    // Abort also releases the requester still holding its request.
                    req_ready_o = sel_oh;
                    rsp_valid_o = sel_oh;
                    rsp_err_o   = 1'b1;
                    err_d       = 1'b1;
                    ptr_d       = sel_next;
                    timer_d     = '0;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            WAIT: begin
                if (mem_rvalid_i) begin
                    rsp_valid_o = sel_oh;
                    ptr_d       = sel_next;
                    timer_d     = '0;
                    if (pick_any) begin
                        sel_d   = pick_idx;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (timeout_hit) begin
                    rsp_valid_o = sel_oh;
                    rsp_err_o   = 1'b1;
                    err_d       = 1'b1;
                    ptr_d       = sel_next;
                    timer_d     = '0;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign sel_o  = sel_q;
    assign busy_o = (state_q != IDLE);
    assign err_o  = err_q;

endmodule

// File: doc/mem_port_arbiter4.md
# mem_port_arbiter4

Round-robin arbiter that shares one memory port among four requesters (e.g. IF fetch, MEM load/store, debug, DMA). It sequences each transaction through request/accept/response phases, drives the 2-bit select of the 32-bit `mux4` that steers requester address/data onto the shared port, and enforces a timeout on a stalled memory.

## Interface

**Parameters**
- `TIMEOUT`, default 255: cycles allowed in ISSUE or WAIT before abort; counter width is `$clog2(TIMEOUT+1)`.

**Ports**
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 4: per-requester request; must be held until that requester's `req_ready`.
- `req_ready`, out, 4: one-hot, single-cycle pulse when the memory accepts the requester's request.
- `rsp_valid`, out, 4: one-hot, single-cycle pulse when the response (or abort) returns to the requester.
- `rsp_err`, out, 1: qualifies `rsp_valid`; 1 means timeout abort.
- `sel`, out, 2: mux4 select; 00/01/10/11 selects requester 0/1/2/3.
- `mem_req`, out, 1: request to the shared memory.
- `mem_gnt`, in, 1: memory accepts the request (sampled only while `mem_req`=1).
- `mem_rvalid`, in, 1: memory response (sampled only in WAIT).
- `busy`, out, 1: state ≠ IDLE.
- `err`, out, 1: sticky timeout flag.
- `err_clr`, in, 1: synchronous clear of `err`.

## Operation

- States: IDLE, ISSUE, WAIT.
- Round-robin pointer `ptr` (2 bits). The pick is the first asserted `req_valid` scanning `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4).
- **IDLE:** if any `req_valid` is set, register `sel` = pick and go to ISSUE. Otherwise stay.
- **ISSUE:** `mem_req`=1.
  - If `mem_gnt`: `req_ready[sel]`=1 this cycle (combinational from `mem_gnt`), clear timer, go to WAIT.
- **WAIT:** `mem_req`=0.
  - If `mem_rvalid`: `rsp_valid[sel]`=1, `rsp_err`=0, `ptr` ← `sel`+1 (wraps 3→0).
  - If any `req_valid` is then set: compute the pick using the updated pointer, register `sel`, go directly to ISSUE.
  - Otherwise go to IDLE.
- **Timeout:** the timer counts every cycle in ISSUE/WAIT and clears on each state change. When it reaches `TIMEOUT`:
  - `rsp_valid[sel]`=1 and `rsp_err`=1.
  - If aborting from ISSUE, also pulse `req_ready[sel]` so the requester releases its request.
  - `err` ← 1, `ptr` ← `sel`+1, go to IDLE.
- If `mem_gnt` or `mem_rvalid` arrives in the timeout cycle, normal progress wins and the timeout is ignored.
- `err_clr` and a timeout in the same cycle leave `err`=1.
- `sel` stays stable from entry to ISSUE until the next pick. Requesters that drop `req_valid` early are a protocol violation and are not checked.
- `req_valid` changes while not in IDLE or at a WAIT exit do not affect the current `sel`.

## Timing

- **Reset values:** state IDLE, `ptr`=0, `sel`=00, timer 0, `err`=0. Combinational outputs are 0 in IDLE (`mem_req`, `req_ready`, `rsp_valid`, `rsp_err`, `busy`).
- Reset is honoured mid-transaction: any state returns to IDLE immediately, and no pulses are emitted.
- **Latency:** `req_valid` high at cycle N while IDLE gives `sel` valid and `mem_req`=1 at N+1.
  - With `mem_gnt` at N+1, `req_ready` pulses at N+1.
  - With `mem_rvalid` at N+2, `rsp_valid` pulses at N+2.
- **Throughput:** minimum 2 cycles per transaction when back-to-back (ISSUE, WAIT, ISSUE, …).

## Structure

- **Shared package `arb_pkg`:**
  - `arb_state_t` enum {IDLE, ISSUE, WAIT}.
  - `localparam NREQ = 4`.
  - `typedef logic [1:0] req_sel_t`.
- **Sub-module `rr_pick4`:** combinational; inputs `req[3:0]` and `ptr[1:0]`; outputs `idx[1:0]` and `any`. It is used at the IDLE and WAIT-exit decisions.
- The top level holds the FSM, pointer, timer and `err` register.
- The `mux4` instance lives in the parent and is driven by `sel`.

## Test plan

- Reset, then `req_valid`=0001, `mem_gnt` at the first ISSUE cycle, `mem_rvalid` one cycle later → `sel`=00, `req_ready`=0001, `rsp_valid`=0001, `ptr`=1, back to IDLE.
- `req_valid`=1111 held for 4 transactions, memory granting immediately → grant order 0,1,2,3 and `sel` sequence 00,01,10,11 with no IDLE cycles in between (2 cycles each).
- `ptr`=3, `req_valid`=0101 → picks 0 (wrap), then 2.
- `TIMEOUT`=4, `mem_gnt` never asserts → on the 4th ISSUE cycle `req_ready` and `rsp_valid` pulse with `rsp_err`=1, `err`=1 and the block returns to IDLE. Then `err_clr` → `err`=0.
- `mem_rvalid` in the same cycle the timer hits `TIMEOUT` → normal response with `rsp_err`=0 and `err` unchanged.
- Assert `rst_n`=0 during WAIT → state IDLE, `sel`=00, `ptr`=0 on the next edge, and no `rsp_valid` pulse.
